// File: rtl/pcq_dbg_trig_pkg.sv
// Shared trigger-state encodings, lane width and a width helper for the debug trace selector.
// Pure declarations: no latency, no flow control.
package pcq_dbg_pkg;

    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARMED  = 2'b01,
        ST_POST   = 2'b10,
        ST_FROZEN = 2'b11
    } trig_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/pcq_dbg_trig_fsm.sv
// Trigger FSM: occurrence counter, post-trigger delay, registered hit pulse; one-cycle state update.
// Counters pause while trace_bus_enable=0; trig_clear is honoured regardless of enable.
module pcq_dbg_trig_fsm
    import pcq_dbg_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int DLY_W = 8
) (
    input  logic             nclk,
    input  logic             rst_b,
    input  logic             en,
    input  logic             trig_arm,
    input  logic             trig_clear,
    input  logic             match,
    input  logic [CNT_W-1:0] trig_thresh,
    input  logic [DLY_W-1:0] trig_post_dly,
    output logic             hold_out,
    output logic             trig_hit,
    output logic [1:0]       trig_state,
    output logic             trig_frozen
);

    trig_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             hit_q, hit_d;
    logic [CNT_W:0]   eff_thresh, cnt_inc;

    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dly_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dly_q   <= dly_d;
            hit_q   <= hit_d;
        end
    end

    // A threshold of zero behaves as one; compare in CNT_W+1 bits so cnt+1 cannot wrap.
    always_comb begin
        eff_thresh = (trig_thresh == '0) ? (CNT_W+1)'(1) : {1'b0, trig_thresh};
        cnt_inc    = {1'b0, cnt_q} + (CNT_W+1)'(1);
        state_d    = state_q;
        cnt_d      = cnt_q;
        dly_d      = dly_q;
        hit_d      = 1'b0;
        if (trig_clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            dly_d   = '0;
        end else if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (trig_arm) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                    end
                end
                ST_ARMED: begin
                    if (match) begin
                        if (cnt_inc >= eff_thresh) begin
                            hit_d = 1'b1;
                            if (trig_post_dly == '0) begin
                                state_d = ST_FROZEN;
                            end else begin
                                state_d = ST_POST;
                                dly_d   = trig_post_dly;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_POST: begin
                    dly_d = dly_q - DLY_W'(1);
                    if (dly_q == DLY_W'(1)) state_d = ST_FROZEN;
                end
                default: ;
            endcase
        end
    end

    // A zero-delay hit freezes the output on the hit edge itself, so the matching value is kept.
    always_comb begin
        hold_out    = (state_q == ST_FROZEN) || (hit_d && (trig_post_dly == '0));
        trig_hit    = hit_q;
        trig_state  = state_q;
        trig_frozen = (state_q == ST_FROZEN);
    end

endmodule

// File: rtl/pcq_dbg_trig.sv
// Debug trace selector: group mux, lane rotate, lane merge with upstream bus, registered output (latency 1).
// trace_bus_enable=0 holds every register; output also holds while the trigger is frozen.
module pcq_dbg_trig
    import pcq_dbg_pkg::*;
#(
    parameter  int NGROUPS = 8,
    parameter  int WIDTH   = 32,
    parameter  int CNT_W   = 8,
    parameter  int DLY_W   = 8,
    localparam int SEL_W   = clog2(NGROUPS),
    localparam int LANES   = WIDTH / LANE_W,
    localparam int ROT_W   = (clog2(LANES) < 1) ? 1 : clog2(LANES)
) (
    input  logic                     nclk,
    input  logic                     rst_b,
    input  logic                     trace_bus_enable,
    input  logic [SEL_W-1:0]         mux_sel,
    input  logic [ROT_W-1:0]         rot_sel,
    input  logic [LANES-1:0]         lane_en,
    input  logic [NGROUPS*WIDTH-1:0] dbg_groups,
    input  logic [WIDTH-1:0]         debug_bus_in,
    input  logic [3:0]               coretrace_ctrls_in,
    input  logic                     trig_arm,
    input  logic                     trig_clear,
    input  logic [WIDTH-1:0]         trig_pattern,
    input  logic [WIDTH-1:0]         trig_mask,
    input  logic [CNT_W-1:0]         trig_thresh,
    input  logic [DLY_W-1:0]         trig_post_dly,
    output logic [WIDTH-1:0]         debug_bus_out,
    output logic [3:0]               coretrace_ctrls_out,
    output logic                     trig_hit,
    output logic [1:0]               trig_state,
    output logic                     trig_frozen
);

    logic [WIDTH-1:0] sel_grp, merged;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic             match, hold_out, load_en;

    // Out-of-range selects fall through to the all-zero default.
    always_comb begin
        sel_grp = '0;
        for (int g = 0; g < NGROUPS; g++) begin
            if (int'(mux_sel) == g) sel_grp = dbg_groups[g*WIDTH +: WIDTH];
        end
    end

    // Right rotate by whole lanes: output lane k takes selected lane (k + rot_sel) mod LANES.
    always_comb begin
        merged = debug_bus_in;
        for (int k = 0; k < LANES; k++) begin
            if (lane_en[k]) begin
                merged[k*LANE_W +: LANE_W] = sel_grp[((k + int'(rot_sel)) % LANES)*LANE_W +: LANE_W];
            end
        end
    end

    assign match   = ((dout_q ^ trig_pattern) & trig_mask) == '0;
    assign load_en = trace_bus_enable && !hold_out;

    always_comb begin
        dout_d = dout_q;
        ctrl_d = ctrl_q;
        if (load_en) begin
            dout_d = merged;
            ctrl_d = coretrace_ctrls_in;
        end
    end

    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            dout_q <= '0;
            ctrl_q <= '0;
        end else begin
            dout_q <= dout_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign debug_bus_out       = dout_q;
    assign coretrace_ctrls_out = ctrl_q;

    pcq_dbg_trig_fsm #(
        .CNT_W (CNT_W),
        .DLY_W (DLY_W)
    ) u_fsm (
        .nclk          (nclk),
        .rst_b         (rst_b),
        .en            (trace_bus_enable),
        .trig_arm      (trig_arm),
        .trig_clear    (trig_clear),
        .match         (match),
        .trig_thresh   (trig_thresh),
        .trig_post_dly (trig_post_dly),
        .hold_out      (hold_out),
        .trig_hit      (trig_hit),
        .trig_state    (trig_state),
        .trig_frozen   (trig_frozen)
    );

endmodule
